// File: rtl/signal_period_meter_pkg.sv
// -----------------------------------------------------------------------------
// signal_period_meter_pkg
//
// Shared constants and types for the period meter and for the board blocks
// that generate the divided clocks and ticks it measures. Keeping the default
// counter width and timeout in one place means the dividers and the meter
// agree on what "one second" of I_clk cycles looks like.
//
// Contents:
//   DEFAULT_CNT_WIDTH   - width of every cycle counter and measurement
//   DEFAULT_TIMEOUT     - cycles without a rising edge before lock is dropped
//   DEFAULT_SYNC_STAGES - synchronizer depth for asynchronous inputs
//   meter_state_e       - measurement FSM states
// -----------------------------------------------------------------------------
package signal_period_meter_pkg;

    localparam int unsigned DEFAULT_CNT_WIDTH   = 27;
    localparam int unsigned DEFAULT_TIMEOUT     = 100000000;
    localparam int unsigned DEFAULT_SYNC_STAGES = 2;

    // WAIT_RISE : no reference edge yet, nothing can be measured
    // FIRST     : one reference rise seen, next rise gives the first result
    // TRACK     : locked, every rise produces a measurement
    typedef enum logic [1:0] {
        WAIT_RISE = 2'd0,
        FIRST     = 2'd1,
        TRACK     = 2'd2
    } meter_state_e;

endpackage : signal_period_meter_pkg

// File: rtl/signal_period_meter_sync_edge_detect.sv
// -----------------------------------------------------------------------------
// sync_edge_detect
//
// Brings an asynchronous level into the I_clk domain through a chain of
// SYNC_STAGES flops, keeps one extra history flop, and produces one-cycle
// rise/fall pulses from the synchronized level. Generic enough to reuse for
// buttons and switches.
//
// Ports:
//   I_clk    - clock, all flops on the rising edge
//   I_rst_n  - synchronous active-low reset, clears every flop
//   I_sig    - asynchronous input level
//   O_level  - synchronized level
//   O_rise   - high for one cycle when the synchronized level goes 0 -> 1
//   O_fall   - high for one cycle when the synchronized level goes 1 -> 0
// -----------------------------------------------------------------------------
module sync_edge_detect
    import signal_period_meter_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic I_clk,
    input  logic I_rst_n,
    input  logic I_sig,
    output logic O_level,
    output logic O_rise,
    output logic O_fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   prev_q;
    logic                   level;

    // Shift the raw input in at bit 0; the last bit is the first one that is
    // safe to use in logic.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], I_sig};
    end

    // Synchronizer chain plus the history flop used for edge detection.
    always_ff @(posedge I_clk) begin
        if (!I_rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level   = sync_q[SYNC_STAGES-1];
    assign O_level = level;

    // Because both pulses compare the same two flops, a rise and a fall can
    // never be asserted in the same cycle.
    assign O_rise = level & ~prev_q;
    assign O_fall = ~level & prev_q;

endmodule : sync_edge_detect

// File: rtl/signal_period_meter.sv
// -----------------------------------------------------------------------------
// signal_period_meter
//
// Measures period and high time of a slow asynchronous square wave in I_clk
// cycles. One free-running counter is restarted at every rising edge; its
// value on the next rising edge is the period and its value on the falling
// edge in between is the high time. Both results are published together so a
// reader never sees a period from one cycle of the input paired with the high
// time of another. Loss of signal is flagged by a timeout on the counter.
//
// Ports:
//   I_clk     - clock, all logic on the rising edge
//   I_rst_n   - synchronous active-low reset
//   I_sig     - asynchronous square wave to measure
//   O_period  - last measured period in cycles
//   O_high    - high time belonging to that same period
//   O_valid   - one-cycle strobe when O_period/O_high have just updated
//   O_locked  - high while measurements are current
// -----------------------------------------------------------------------------
module signal_period_meter
    import signal_period_meter_pkg::*;
#(
    parameter int unsigned CNT_WIDTH   = DEFAULT_CNT_WIDTH,
    parameter int unsigned TIMEOUT     = DEFAULT_TIMEOUT,
    parameter int unsigned SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic                 I_clk,
    input  logic                 I_rst_n,
    input  logic                 I_sig,
    output logic [CNT_WIDTH-1:0] O_period,
    output logic [CNT_WIDTH-1:0] O_high,
    output logic                 O_valid,
    output logic                 O_locked
);

    localparam logic [CNT_WIDTH-1:0] TIMEOUT_C = CNT_WIDTH'(TIMEOUT);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

    logic                 sigLevel;
    logic                 rise;
    logic                 fall;

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic [CNT_WIDTH-1:0] highShadow_q;
    logic [CNT_WIDTH-1:0] period_q;
    logic [CNT_WIDTH-1:0] high_q;
    logic                 valid_q;
    logic                 locked_q;
    meter_state_e         state_q;

    sync_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge_detect (
        .I_clk   (I_clk),
        .I_rst_n (I_rst_n),
        .I_sig   (I_sig),
        .O_level (sigLevel),
        .O_rise  (rise),
        .O_fall  (fall)
    );

    // The synchronized level itself is not needed here; only its edges are.
    logic unusedLevel;
    assign unusedLevel = sigLevel;

    // Cycle counter: restarts at 1 on a rise so that its value in the next
    // rise cycle equals the period. Saturates instead of wrapping so a dead
    // input can never alias back into a plausible period.
    always_comb begin
        cnt_d = cnt_q;
        if (rise) begin
            cnt_d = CNT_ONE;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge I_clk) begin
        if (!I_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Measurement FSM with registered outputs. The first rise after reset or
    // timeout only establishes a reference; the partial period before it is
    // meaningless, so nothing is reported until the next rise. The high time
    // is parked in a shadow register at the fall and only published together
    // with the period, which keeps the pair coherent. A rise in the same
    // cycle as the timeout wins, so a period of exactly TIMEOUT is still
    // measurable.
    always_ff @(posedge I_clk) begin
        if (!I_rst_n) begin
            state_q      <= WAIT_RISE;
            highShadow_q <= '0;
            period_q     <= '0;
            high_q       <= '0;
            valid_q      <= 1'b0;
            locked_q     <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                WAIT_RISE: begin
                    if (rise) begin
                        state_q <= FIRST;
                    end
                end
                FIRST, TRACK: begin
                    if (fall) begin
                        highShadow_q <= cnt_q;
                    end
                    if (rise) begin
                        period_q <= cnt_q;
                        high_q   <= highShadow_q;
                        valid_q  <= 1'b1;
                        locked_q <= 1'b1;
                        state_q  <= TRACK;
                    end else if (cnt_q == TIMEOUT_C) begin
                        locked_q <= 1'b0;
                        state_q  <= WAIT_RISE;
                    end
                end
                default: begin
                    state_q <= WAIT_RISE;
                end
            endcase
        end
    end

    assign O_period = period_q;
    assign O_high   = high_q;
    assign O_valid  = valid_q;
    assign O_locked = locked_q;

endmodule : signal_period_meter

// File: tb/tb_signal_period_meter.sv
// -----------------------------------------------------------------------------
// tb_signal_period_meter
//
// Drives the meter with square-wave segments (directed and random high/low
// lengths) and predicts each report from the waveform itself: a report is due
// at every rise whose preceding rise was at most TIMEOUT cycles earlier, and
// it carries the distance between the two rises and the high time in between.
// Expected reports go into a queue; a monitor pops one whenever O_valid is
// seen and compares values, arrival cycle and lock.
// -----------------------------------------------------------------------------
module tb_signal_period_meter;

    localparam int CNT_WIDTH   = 27;
    localparam int TIMEOUT     = 50;
    localparam int SYNC_STAGES = 2;

    typedef struct {
        int period;
        int high;
        int cyc;
    } exp_t;

    logic                 I_clk = 1'b0;
    logic                 I_rst_n;
    logic                 I_sig;
    logic [CNT_WIDTH-1:0] O_period;
    logic [CNT_WIDTH-1:0] O_high;
    logic                 O_valid;
    logic                 O_locked;

    int   assertCount = 0;
    int   failCount   = 0;
    int   cyc         = 0;
    exp_t expQ[$];
    exp_t popped;

    // Reference model state: distance since the last input rise and the
    // high time of that segment.
    bit   haveRef    = 1'b0;
    int   prevLen    = 0;
    int   prevHigh   = 0;
    int   lastPeriod = 0;
    int   lastHigh   = 0;

    signal_period_meter #(
        .CNT_WIDTH   (CNT_WIDTH),
        .TIMEOUT     (TIMEOUT),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .I_clk    (I_clk),
        .I_rst_n  (I_rst_n),
        .I_sig    (I_sig),
        .O_period (O_period),
        .O_high   (O_high),
        .O_valid  (O_valid),
        .O_locked (O_locked)
    );

    always #5 I_clk = ~I_clk;

    always @(posedge I_clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)",
                     name, actual, expected, cyc);
        end
    endtask

    // Scoreboard monitor: every strobe must match the oldest pending report.
    always @(negedge I_clk) begin
        if (I_rst_n === 1'b1 && O_valid === 1'b1) begin
            if (expQ.size() == 0) begin
                assertCount++;
                failCount++;
                $display("[TB] FAIL unexpected_valid: got O_valid=1 with period %0d high %0d, expected no report (cycle %0d)",
                         O_period, O_high, cyc);
            end else begin
                popped = expQ.pop_front();
                checkOutput("period", 64'(O_period), 64'(popped.period));
                checkOutput("high", 64'(O_high), 64'(popped.high));
                checkOutput("valid_cycle", 64'(cyc), 64'(popped.cyc));
                checkOutput("locked_on_valid", 64'(O_locked), 64'd1);
            end
        end
    end

    // One input period: rise now, high for h cycles, low for l cycles.
    // Always entered and left on a falling clock edge.
    task automatic applyStimulus(input int h, input int l);
        if (haveRef && prevLen <= TIMEOUT) begin
            expQ.push_back('{prevLen, prevHigh, cyc + 1 + SYNC_STAGES});
            lastPeriod = prevLen;
            lastHigh   = prevHigh;
        end
        haveRef  = 1'b1;
        prevLen  = h + l;
        prevHigh = h;
        I_sig = 1'b1;
        repeat (h) @(negedge I_clk);
        I_sig = 1'b0;
        repeat (l) @(negedge I_clk);
    endtask

    task automatic holdLow(input int n);
        prevLen += n;
        I_sig = 1'b0;
        repeat (n) @(negedge I_clk);
    endtask

    task automatic pulseReset(input string tag);
        I_rst_n = 1'b0;
        @(negedge I_clk);
        checkOutput({tag, "_period"}, 64'(O_period), 64'd0);
        checkOutput({tag, "_high"}, 64'(O_high), 64'd0);
        checkOutput({tag, "_valid"}, 64'(O_valid), 64'd0);
        checkOutput({tag, "_locked"}, 64'(O_locked), 64'd0);
        I_rst_n    = 1'b1;
        haveRef    = 1'b0;
        lastPeriod = 0;
        lastHigh   = 0;
    endtask

    task automatic checkTimedOut(input string tag);
        checkOutput({tag, "_locked"}, 64'(O_locked), 64'd0);
        checkOutput({tag, "_period_held"}, 64'(O_period), 64'(lastPeriod));
        checkOutput({tag, "_high_held"}, 64'(O_high), 64'(lastHigh));
    endtask

    initial begin
        I_sig   = 1'b0;
        I_rst_n = 1'b0;
        repeat (2) @(negedge I_clk);
        pulseReset("reset");
        holdLow(3);

        // Basic: period 10, high 4
        for (int i = 0; i < 6; i++) applyStimulus(4, 6);

        // Period change 10/5 -> 20/15, never a mixed pair
        for (int i = 0; i < 4; i++) applyStimulus(5, 5);
        for (int i = 0; i < 4; i++) applyStimulus(15, 5);

        // Loss of signal, then restart
        holdLow(80);
        checkTimedOut("timeout");
        for (int i = 0; i < 4; i++) applyStimulus(4, 6);

        // Period exactly at the timeout
        for (int i = 0; i < 4; i++) applyStimulus(20, 30);
        applyStimulus(2, 2);
        checkOutput("locked_at_timeout_period", 64'(O_locked), 64'd1);

        // Reset in the middle of tracking
        applyStimulus(6, 3);
        pulseReset("midreset");
        holdLow(3);
        for (int i = 0; i < 3; i++) applyStimulus(3, 3);

        // Fastest input
        for (int i = 0; i < 10; i++) applyStimulus(1, 1);

        // Random segments, some longer than the timeout
        for (int i = 0; i < 40; i++) begin
            applyStimulus(int'($urandom_range(30, 1)), int'($urandom_range(30, 1)));
        end

        holdLow(80);
        checkTimedOut("final_timeout");
        checkOutput("scoreboard_drained", 64'(expQ.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assertCount, failCount);
        $finish;
    end

endmodule : tb_signal_period_meter
